uengine_spi_responder: RTL
==========================

# uengine_spi_responder

Chip-side SPI responder that terminates the 32-bit engine register frames issued by the host-side uEngine sequencers. It oversamples SCK/CS/MOSI in the SysClock domain, decodes {R/W, chip, engine, register, data}, and filters on the local chip index. It then issues a one-cycle write strobe or a read request/acknowledge to the engine register bank, and shifts the 16-bit read result back on MISO, MSB first.

## Interface
- SYNC_STAGES, 2, synchronizer depth on SPI_SCK, SPI_CS_N and SPI_MOSI (≥2).
- SysClock  in  1  system clock; all logic on rising edge.
- SysReset  in  1  asynchronous, active-high reset.
- SPI_SCK  in  1  SPI clock, mode 0 (idle low, sample on rising, shift on falling).
- SPI_CS_N  in  1  chip select, active low.
- SPI_MOSI  in  1  serial data from the host.
- SPI_MISO  out  1  serial data to the host.
- SPI_MISO_OE  out  1  MISO output enable; high only while answering a matching read.
- ChipIndex  in  3  local chip address, compared against frame bits [30:28].
- REG_ENGINE  out  4  engine address, frame bits [27:24]; held from header completion to the next frame.
- REG_ADDR  out  8  register address, frame bits [23:16]; held the same way.
- REG_RD_REQ  out  1  one-cycle read request.
- REG_RD_ACK  in  1  read data valid; qualifies REG_RD_DATA.
- REG_RD_DATA  in  16  read data.
- REG_WR_STROBE  out  1  one-cycle write strobe.
- REG_WR_DATA  out  16  write data, frame bits [15:0]; valid with the strobe and held afterwards.
- ErrorCount  out  8  saturating count of aborted frames and read timeouts.
- DebugExport  out  32  {22'b0, BitCnt[5:0], State[3:0]}.

## Operation
- Frame, MSB first: bit31 = 1 for read, 0 for write; [30:28] chip; [27:24] engine; [23:16] register; [15:0] write data (don't care on reads).
- Edge detection: rising/falling SCK = synchronized SCK differs from its previous registered value. A CS_N low→high transition on synchronized CS_N is a deselect.
- BitCnt (6 bits) counts rising edges from 0 to 32. It stops at 32; any extra edges are ignored.
- States:
  - IDLE: CS_N high, BitCnt = 0, OE = 0. Go to HEADER on synchronized CS_N low.
  - HEADER: shift MOSI into ShiftReg on each rising edge. On the 16th edge, latch REG_ENGINE and REG_ADDR, and set Match = (bits[30:28] == ChipIndex).
    - Read with Match: pulse REG_RD_REQ, go to RD_WAIT.
    - Otherwise: go to DATA.
  - RD_WAIT: on REG_RD_ACK, latch RespReg = REG_RD_DATA and go to DATA. If the next SCK falling edge arrives first, set RespReg = 16'h0000, increment ErrorCount, go to DATA; a late ACK is ignored.
  - DATA: for a matched read, SPI_MISO_OE = 1. On each falling edge, SPI_MISO = RespReg[15] and RespReg shifts left. Continue sampling MOSI. On the 32nd rising edge, for a matched write, pulse REG_WR_STROBE with REG_WR_DATA = bits[15:0]. Go to DONE.
  - DONE: OE = 0. Wait for deselect, then go to IDLE.
- Deselect in HEADER, RD_WAIT or DATA: abort to IDLE. No strobe is issued; ErrorCount increments if BitCnt > 0.
- A deselect detected in the same cycle as the 32nd rising edge wins: abort, no write strobe.
- Non-matching frames never assert REG_RD_REQ, REG_WR_STROBE or SPI_MISO_OE.
- ErrorCount saturates at 8'hFF.
- SysReset mid-frame clears all state; no strobe is issued afterwards for the interrupted frame.

## Timing
- Reset values: SPI_MISO = 0, SPI_MISO_OE = 0, REG_RD_REQ = 0, REG_WR_STROBE = 0, REG_ENGINE = 0, REG_ADDR = 0, REG_WR_DATA = 0, ErrorCount = 0, DebugExport = 0, state IDLE.
- Input latency: SYNC_STAGES + 1 SysClock cycles from a pin change to edge detection.
- REG_RD_REQ: asserted one cycle after detection of the 16th rising edge, for exactly 1 cycle.
- REG_WR_STROBE: asserted one cycle after detection of the 32nd rising edge, for exactly 1 cycle.
- MISO: updates one cycle after falling-edge detection.
- Requirement: SysClock ≥ 8× SCK frequency.
- REG_RD_ACK is accepted from the cycle after REG_RD_REQ up to the cycle before detection of the next falling edge.
- OE drops one cycle after the 32nd rising edge or after a deselect.

## Test plan
- Write match: ChipIndex = 3, frame 0x3A5C_1234 -> exactly one REG_WR_STROBE with REG_ENGINE = 0xA, REG_ADDR = 0x5C, REG_WR_DATA = 0x1234; REG_RD_REQ never asserts; ErrorCount = 0.
- Read match: ChipIndex = 5, frame 0xD300_0000, REG_RD_ACK 3 cycles after REG_RD_REQ with data 0x0002 -> MISO carries 0x0002 over the last 16 bits; OE high only during bits 15..0; no write strobe.
- Chip mismatch: ChipIndex = 0, read and write frames with chip = 7 -> no REG_RD_REQ, no REG_WR_STROBE, OE stays 0, ErrorCount = 0.
- Abort: CS_N raised after 20 SCK edges of a matching write -> no strobe, ErrorCount = 1, state back to IDLE; the next full frame completes normally.
- Read timeout: REG_RD_ACK withheld -> MISO shifts 0x0000, ErrorCount increments by 1; an ACK arriving after the deadline has no effect.
- Reset mid-frame: SysReset pulsed after 24 edges of a matching write -> all outputs at reset values immediately, no strobe; a frame after release is decoded correctly.

Source files
------------

// File: rtl/uengine_spi_responder.sv
// Chip-side SPI mode-0 responder for 32-bit uEngine register frames.
// Oversamples the SPI pins, decodes read/write frames and drives MISO for matched reads.
module uengine_spi_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        SysClock,
   input  logic        SysReset,
   input  logic        SPI_SCK,
   input  logic        SPI_CS_N,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic        SPI_MISO_OE,
   input  logic [2:0]  ChipIndex,
   output logic [3:0]  REG_ENGINE,
   output logic [7:0]  REG_ADDR,
   output logic        REG_RD_REQ,
   input  logic        REG_RD_ACK,
   input  logic [15:0] REG_RD_DATA,
   output logic        REG_WR_STROBE,
   output logic [15:0] REG_WR_DATA,
   output logic [7:0]  ErrorCount,
   output logic [31:0] DebugExport
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      HEADER  = 4'd1,
      RD_WAIT = 4'd2,
      DATA    = 4'd3,
      DONE    = 4'd4
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
   logic                   sck_prev, cs_prev;
   logic                   sck_s, cs_s, mosi_s;
   logic                   sck_rise, sck_fall, cs_desel;

   state_t      state_reg, state_next;
   logic [5:0]  bit_cnt_reg, bit_cnt_next;
   logic [14:0] shift_reg, shift_next;
   logic        match_reg, match_next;
   logic        read_reg, read_next;
   logic [15:0] resp_reg, resp_next;
   logic        miso_reg, miso_next;
   logic        oe_reg, oe_next;
   logic        rd_req_reg, rd_req_next;
   logic        wr_strobe_reg, wr_strobe_next;
   logic [3:0]  engine_reg, engine_next;
   logic [7:0]  addr_reg, addr_next;
   logic [15:0] wr_data_reg, wr_data_next;
   logic [7:0]  err_reg, err_next;

   logic [15:0] shifted;
   logic [5:0]  cnt_inc;
   logic        err_inc;

   // CS_N chain resets high so a reset never looks like a deselect or a frame start
   always_ff @(posedge SysClock or posedge SysReset) begin
      if (SysReset) begin
         sck_sync  <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sck_prev  <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         sck_prev  <= sck_sync[SYNC_STAGES-1];
         cs_prev   <= cs_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev;
   assign sck_fall = ~sck_s & sck_prev;
   assign cs_desel = cs_s & ~cs_prev;

   always_ff @(posedge SysClock or posedge SysReset) begin
      if (SysReset) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         match_reg     <= 1'b0;
         read_reg      <= 1'b0;
         resp_reg      <= '0;
         miso_reg      <= 1'b0;
         oe_reg        <= 1'b0;
         rd_req_reg    <= 1'b0;
         wr_strobe_reg <= 1'b0;
         engine_reg    <= '0;
         addr_reg      <= '0;
         wr_data_reg   <= '0;
         err_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         match_reg     <= match_next;
         read_reg      <= read_next;
         resp_reg      <= resp_next;
         miso_reg      <= miso_next;
         oe_reg        <= oe_next;
         rd_req_reg    <= rd_req_next;
         wr_strobe_reg <= wr_strobe_next;
         engine_reg    <= engine_next;
         addr_reg      <= addr_next;
         wr_data_reg   <= wr_data_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      match_next     = match_reg;
      read_next      = read_reg;
      resp_next      = resp_reg;
      miso_next      = miso_reg;
      oe_next        = oe_reg;
      rd_req_next    = 1'b0;
      wr_strobe_next = 1'b0;
      engine_next    = engine_reg;
      addr_next      = addr_reg;
      wr_data_next   = wr_data_reg;
      err_inc        = 1'b0;
      shifted        = {shift_reg, mosi_s};
      cnt_inc        = bit_cnt_reg + 6'd1;

      if ((state_reg == HEADER || state_reg == RD_WAIT || state_reg == DATA) && cs_desel) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         oe_next      = 1'b0;
         err_inc      = (bit_cnt_reg != 6'd0);
      end else begin
         if ((state_reg == HEADER || state_reg == RD_WAIT || state_reg == DATA) && sck_rise) begin
            shift_next   = shifted[14:0];
            bit_cnt_next = cnt_inc;
         end
         case (state_reg)
            IDLE: begin
               bit_cnt_next = '0;
               oe_next      = 1'b0;
               if (!cs_s) state_next = HEADER;
            end
            HEADER: begin
               if (sck_rise && cnt_inc == 6'd16) begin
                  engine_next = shifted[11:8];
                  addr_next   = shifted[7:0];
                  match_next  = (shifted[14:12] == ChipIndex);
                  read_next   = shifted[15];
                  if (shifted[15] && shifted[14:12] == ChipIndex) begin
                     rd_req_next = 1'b1;
                     state_next  = RD_WAIT;
                  end else begin
                     state_next  = DATA;
                  end
               end
            end
            RD_WAIT: begin
               // The first response bit is due on this falling edge; without data it is zero
               if (sck_fall) begin
                  resp_next  = '0;
                  miso_next  = 1'b0;
                  oe_next    = 1'b1;
                  err_inc    = 1'b1;
                  state_next = DATA;
               end else if (REG_RD_ACK && !rd_req_reg) begin
                  resp_next  = REG_RD_DATA;
                  oe_next    = 1'b1;
                  state_next = DATA;
               end
            end
            DATA: begin
               if (sck_fall && match_reg && read_reg) begin
                  miso_next = resp_reg[15];
                  resp_next = {resp_reg[14:0], 1'b0};
               end
               if (sck_rise && cnt_inc == 6'd32) begin
                  if (match_reg && !read_reg) begin
                     wr_strobe_next = 1'b1;
                     wr_data_next   = shifted;
                  end
                  oe_next    = 1'b0;
                  state_next = DONE;
               end
            end
            DONE: begin
               oe_next = 1'b0;
               if (cs_desel) begin
                  state_next   = IDLE;
                  bit_cnt_next = '0;
               end
            end
            default: state_next = IDLE;
         endcase
      end

      err_next = (err_inc && err_reg != 8'hFF) ? err_reg + 8'd1 : err_reg;
   end

   assign SPI_MISO      = miso_reg;
   assign SPI_MISO_OE   = oe_reg;
   assign REG_RD_REQ    = rd_req_reg;
   assign REG_WR_STROBE = wr_strobe_reg;
   assign REG_ENGINE    = engine_reg;
   assign REG_ADDR      = addr_reg;
   assign REG_WR_DATA   = wr_data_reg;
   assign ErrorCount    = err_reg;
   assign DebugExport   = {22'b0, bit_cnt_reg, state_reg};

endmodule
